forward_pass_scheduler: RTL and testbench

Parameterised sequencer that runs one forward pass of the cached dilated causal conv network per `sample_clk` rising edge. It pulses the input left-shift-buffer clock, then starts each conv stage in order, waits for its `out_v`, and optionally clocks the following activation cache. It signals output latch, measures pass length, and flags overruns and hung stages. It replaces the hand-written per-layer case statement in `network` with one reusable, verifiable block.

---
 rtl/forward_pass_scheduler.sv | 268 ++++++++++++++++++++++++++
 tb/tb_forward_pass_scheduler.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/forward_pass_scheduler.sv
// forward_pass_scheduler
//
// This block runs one forward pass of the cached dilated causal conv network
// for each rising edge of sample_clk. A pass pulses the left-shift buffers and
// then starts each conv stage in order. After each start it waits for that
// stage's result-valid. Where CACHE_AFTER selects it, the following activation
// cache is clocked next. At the end the block signals that the final output
// can be latched. It also records the pass length and flags dropped requests.
//
// Build option SCHED_TIMEOUT_EN:
//   defined   - each stage wait is bounded to TIMEOUT cycles. A hung stage
//               aborts the pass and reports its index.
//   undefined - the wait is unbounded; timeout_err and timeout_stage read 0.
//
// Ports:
//   clk, rst        system clock; asynchronous active-high reset
//   sample_clk      asynchronous pass request (rising edge)
//   stage_out_v     per-stage result-valid
//   clear_err       one-cycle clear of overrun/timeout flags and counters
//   lsb_clk         one-cycle pulse to the left-shift buffers
//   stage_rst       one-hot start pulse to stage i
//   cache_clk       one-hot pulse to the activation cache after stage i
//   out_latch       one-cycle pulse: the final stage output is valid
//   busy            a pass is in progress
//   pass_cycles     length of the last completed pass, START..DONE inclusive
//   overrun         sticky: a request arrived while busy and was dropped
//   overrun_count   saturating count of dropped requests
//   timeout_err     sticky: a stage failed to complete in time
//   timeout_stage   index of the stage that timed out
//
// state | meaning
// IDLE  | waiting for a synchronised request
// START | lsb_clk pulse, stage index reset to 0
// RST   | stage_rst[idx] pulse, wait timer loaded
// WAIT  | waiting for stage_out_v[idx]; the first cycle is ignored
// CACHE | cache_clk[idx] pulse
// DONE  | out_latch pulse, pass length captured

module forward_pass_scheduler #(
  parameter int unsigned          N_STAGES    = 7,
  parameter logic [N_STAGES-1:0]  CACHE_AFTER = 7'b0100010,
  parameter int unsigned          TIMEOUT     = 1024,
  parameter int unsigned          CNT_W       = 32,
  localparam int unsigned         IW          = (N_STAGES > 1) ? $clog2(N_STAGES) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sample_clk,
  input  logic [N_STAGES-1:0] stage_out_v,
  input  logic                clear_err,
  output logic                lsb_clk,
  output logic [N_STAGES-1:0] stage_rst,
  output logic [N_STAGES-1:0] cache_clk,
  output logic                out_latch,
  output logic                busy,
  output logic [CNT_W-1:0]    pass_cycles,
  output logic                overrun,
  output logic [15:0]         overrun_count,
  output logic                timeout_err,
  output logic [IW-1:0]       timeout_stage
);

  localparam int unsigned   WW        = $clog2(TIMEOUT);
  // The wait timer counts down from TIMEOUT-1. It still holds the load value
  // only in the first WAIT cycle, and it reaches zero in WAIT cycle TIMEOUT.
  localparam logic [WW-1:0] WAIT_LOAD = WW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_RST, S_WAIT, S_CACHE, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [WW-1:0]       wait_q, wait_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    pass_cycles_q, pass_cycles_d;
  logic                sync1_q, sync2_q, sync3_q;
  logic                lsb_clk_q, lsb_clk_d;
  logic [N_STAGES-1:0] stage_rst_q, stage_rst_d;
  logic [N_STAGES-1:0] cache_clk_q, cache_clk_d;
  logic                out_latch_q, out_latch_d;
  logic                busy_q, busy_d;
  logic                overrun_q, overrun_d;
  logic [15:0]         ovr_cnt_q, ovr_cnt_d;
  logic                req;
  logic                busy_now;
  logic                last_stage;

`ifdef SCHED_TIMEOUT_EN
  logic                tmo_hit;
  logic                tmo_err_q, tmo_err_d;
  logic [IW-1:0]       tmo_stage_q, tmo_stage_d;
`endif

  // Rising edge of the synchronised strobe, one cycle wide.
  assign req        = sync2_q & ~sync3_q;
  assign busy_now   = (state_q != S_IDLE);
  assign last_stage = (idx_q == IW'(N_STAGES - 1));

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    wait_d        = wait_q;
    cnt_d         = cnt_q;
    pass_cycles_d = pass_cycles_q;
`ifdef SCHED_TIMEOUT_EN
    tmo_hit       = 1'b0;
`endif
    if (busy_now) cnt_d = cnt_q + CNT_W'(1);

    case (state_q)
      S_IDLE: begin
        if (req) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        idx_d   = '0;
        state_d = S_RST;
      end
      S_RST: begin
        wait_d  = WAIT_LOAD;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if ((wait_q != WAIT_LOAD) && stage_out_v[idx_q]) begin
          if (CACHE_AFTER[idx_q]) begin
            state_d = S_CACHE;
          end else if (last_stage) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + IW'(1);
            state_d = S_RST;
          end
        end else if (wait_q != '0) begin
          wait_d = wait_q - WW'(1);
        end
`ifdef SCHED_TIMEOUT_EN
        else begin
          tmo_hit = 1'b1;
          state_d = S_IDLE;
        end
`endif
      end
      S_CACHE: begin
        if (last_stage) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + IW'(1);
          state_d = S_RST;
        end
      end
      S_DONE: begin
        // cnt_q has counted every cycle of the pass before this one.
        pass_cycles_d = cnt_q + CNT_W'(1);
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Pulses are decoded from the next state, so each flop is high exactly in
  // the cycle its state is current.
  always_comb begin
    lsb_clk_d   = (state_d == S_START);
    out_latch_d = (state_d == S_DONE);
    busy_d      = (state_d != S_IDLE);
    stage_rst_d = '0;
    cache_clk_d = '0;
    for (int i = 0; i < int'(N_STAGES); i++) begin
      stage_rst_d[i] = (state_d == S_RST)   && (idx_d == IW'(i));
      cache_clk_d[i] = (state_d == S_CACHE) && (idx_d == IW'(i));
    end
  end

  // A request that is dropped in the same cycle as clear_err still counts.
  always_comb begin
    overrun_d = overrun_q;
    ovr_cnt_d = ovr_cnt_q;
    if (clear_err) begin
      overrun_d = 1'b0;
      ovr_cnt_d = '0;
    end
    if (req && busy_now) begin
      overrun_d = 1'b1;
      if (clear_err)                 ovr_cnt_d = 16'd1;
      else if (ovr_cnt_q != 16'hFFFF) ovr_cnt_d = ovr_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      wait_q        <= '0;
      cnt_q         <= '0;
      pass_cycles_q <= '0;
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      sync3_q       <= 1'b0;
      lsb_clk_q     <= 1'b0;
      stage_rst_q   <= '0;
      cache_clk_q   <= '0;
      out_latch_q   <= 1'b0;
      busy_q        <= 1'b0;
      overrun_q     <= 1'b0;
      ovr_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      wait_q        <= wait_d;
      cnt_q         <= cnt_d;
      pass_cycles_q <= pass_cycles_d;
      sync1_q       <= sample_clk;
      sync2_q       <= sync1_q;
      sync3_q       <= sync2_q;
      lsb_clk_q     <= lsb_clk_d;
      stage_rst_q   <= stage_rst_d;
      cache_clk_q   <= cache_clk_d;
      out_latch_q   <= out_latch_d;
      busy_q        <= busy_d;
      overrun_q     <= overrun_d;
      ovr_cnt_q     <= ovr_cnt_d;
    end
  end

`ifdef SCHED_TIMEOUT_EN
  always_comb begin
    tmo_err_d   = tmo_err_q;
    tmo_stage_d = tmo_stage_q;
    if (clear_err) begin
      tmo_err_d   = 1'b0;
      tmo_stage_d = '0;
    end
    if (tmo_hit) begin
      tmo_err_d   = 1'b1;
      tmo_stage_d = idx_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_err_q   <= 1'b0;
      tmo_stage_q <= '0;
    end else begin
      tmo_err_q   <= tmo_err_d;
      tmo_stage_q <= tmo_stage_d;
    end
  end

  assign timeout_err   = tmo_err_q;
  assign timeout_stage = tmo_stage_q;
`else
  assign timeout_err   = 1'b0;
  assign timeout_stage = '0;
`endif

  assign lsb_clk       = lsb_clk_q;
  assign stage_rst     = stage_rst_q;
  assign cache_clk     = cache_clk_q;
  assign out_latch     = out_latch_q;
  assign busy          = busy_q;
  assign pass_cycles   = pass_cycles_q;
  assign overrun       = overrun_q;
  assign overrun_count = ovr_cnt_q;

endmodule

// File: tb/tb_forward_pass_scheduler.sv
// Bench for forward_pass_scheduler with N_STAGES=3, CACHE_AFTER=3'b011 and
// TIMEOUT=8. Each conv stage is modelled as raising out_v a programmable
// number of cycles after its start pulse. The expected pulse order, pass
// length and overrun count are worked out from the sequencing rules.
module tb_forward_pass_scheduler;
  localparam int          N  = 3;
  localparam int          TO = 8;
  localparam int          CW = 32;
  localparam logic [N-1:0] CA = 3'b011;

  logic          clk, rst, sample_clk, clear_err;
  logic [N-1:0]  stage_out_v;
  logic          lsb_clk;
  logic [N-1:0]  stage_rst, cache_clk;
  logic          out_latch, busy;
  logic [CW-1:0] pass_cycles;
  logic          overrun;
  logic [15:0]   overrun_count;
  logic          timeout_err;
  logic [1:0]    timeout_stage;

  forward_pass_scheduler #(
    .N_STAGES(N), .CACHE_AFTER(CA), .TIMEOUT(TO), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .sample_clk(sample_clk), .stage_out_v(stage_out_v),
    .clear_err(clear_err), .lsb_clk(lsb_clk), .stage_rst(stage_rst),
    .cache_clk(cache_clk), .out_latch(out_latch), .busy(busy),
    .pass_cycles(pass_cycles), .overrun(overrun), .overrun_count(overrun_count),
    .timeout_err(timeout_err), .timeout_stage(timeout_stage)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, n_pass=%0d n_checks=%0d", n_pass, n_checks);
    $fatal(1);
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Stage models: out_v[i] rises delay_c[i] cycles after stage_rst[i].
  // A stale stage holds out_v high throughout.
  int  delay_c[N];
  bit  hang[N];
  bit  stale[N];
  int  wcnt[N];
  bit  active[N];

  initial begin
    stage_out_v = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stage_out_v = '0;
        for (int i = 0; i < N; i++) active[i] = 1'b0;
      end else begin
        for (int i = 0; i < N; i++) begin
          if (stage_rst[i]) begin
            wcnt[i]        = 0;
            active[i]      = 1'b1;
            stage_out_v[i] = stale[i];
          end else if (active[i]) begin
            wcnt[i]++;
            if (!hang[i] && wcnt[i] == delay_c[i]) stage_out_v[i] = 1'b1;
          end
          if (stale[i]) stage_out_v[i] = 1'b1;
        end
      end
    end
  end

  // Pulse log: 1 = lsb_clk, 10+i = stage_rst[i], 20+i = cache_clk[i], 30 = out_latch.
  int evq[$];
  int expq[$];
  int n_multi = 0;
  int n_this;

  initial begin
    forever begin
      @(negedge clk);
      n_this = 0;
      if (lsb_clk) begin evq.push_back(1); n_this++; end
      for (int i = 0; i < N; i++) begin
        if (stage_rst[i]) begin evq.push_back(10 + i); n_this++; end
        if (cache_clk[i]) begin evq.push_back(20 + i); n_this++; end
      end
      if (out_latch) begin evq.push_back(30); n_this++; end
      if (n_this > 1) n_multi++;
    end
  end

  logic [N-1:0] ca_v;
  int exp_ovr = 0;

  task automatic build_exp(input int upto, input bit with_latch);
    expq.delete();
    expq.push_back(1);
    for (int i = 0; i <= upto; i++) begin
      expq.push_back(10 + i);
      if (ca_v[i] && (with_latch || i < upto)) expq.push_back(20 + i);
    end
    if (with_latch) expq.push_back(30);
  endtask

  task automatic check_order(input string tag);
    check_eq({tag, "_len"}, 64'(evq.size()), 64'(expq.size()));
    for (int k = 0; k < expq.size(); k++)
      if (k < evq.size()) check_eq(tag, 64'(evq[k]), 64'(expq[k]));
  endtask

  // START + per stage (RST + WAIT cycles) + cache pulses + DONE.
  // The valid is sampled from the second WAIT cycle onwards.
  function automatic int exp_len();
    int t;
    t = 2;
    for (int i = 0; i < N; i++) begin
      t += 1 + ((stale[i] || delay_c[i] < 2) ? 2 : delay_c[i]);
      if (ca_v[i]) t++;
    end
    return t;
  endfunction

  task automatic start_req(output int lat);
    lat = 0;
    @(negedge clk);
    sample_clk = 1'b1;
    do begin
      @(negedge clk);
      lat++;
    end while (!lsb_clk && lat < 20);
    sample_clk = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 400) begin
      @(negedge clk);
      k++;
    end
    check_eq("pass_end_busy", 64'(busy), 64'd0);
  endtask

  task automatic wait_rst(input int i);
    int k;
    k = 0;
    while (!stage_rst[i] && k < 100) begin
      @(negedge clk);
      k++;
    end
    check_eq("saw_stage_rst", 64'(stage_rst[i]), 64'd1);
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    exp_ovr = 0;
  endtask

  task automatic check_flags(input string tag);
    check_eq({tag, "_ovr_count"}, 64'(overrun_count), 64'(exp_ovr));
    check_eq({tag, "_overrun"}, 64'(overrun), 64'(exp_ovr != 0));
  endtask

  task automatic do_pass(input int extra);
    int lat;
    evq.delete();
    start_req(lat);
    check_eq("latency", 64'(lat), 64'd3);
    for (int k = 0; k < extra; k++) begin
      @(negedge clk); sample_clk = 1'b1;
      @(negedge clk); sample_clk = 1'b0;
    end
    wait_idle();
    exp_ovr = (exp_ovr + extra > 65535) ? 65535 : exp_ovr + extra;
    build_exp(N - 1, 1'b1);
    check_order("order");
    check_eq("pass_cycles", 64'(pass_cycles), 64'(exp_len()));
    check_flags("pass");
  endtask

  task automatic set_delays(input int d);
    for (int i = 0; i < N; i++) delay_c[i] = d;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("rst_outputs",
             64'({lsb_clk, stage_rst, cache_clk, out_latch, busy, overrun,
                  timeout_err, timeout_stage, overrun_count}), 64'd0);
    check_eq("rst_pass_cycles", 64'(pass_cycles), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_ovr = 0;
  endtask

  int lat;
  logic [CW-1:0] prev_pc;

  initial begin
    rst = 1'b0; sample_clk = 1'b0; clear_err = 1'b0;
    ca_v = CA;
    for (int i = 0; i < N; i++) begin hang[i] = 0; stale[i] = 0; end
    set_delays(3);
    pulse_reset();

    // Single pass, nominal stage latency.
    do_pass(0);
    check_eq("single_pass_len", 64'(pass_cycles), 64'd16);

    // Stale valid on stage 0: WAIT still lasts two cycles.
    stale[0] = 1'b1;
    do_pass(0);
    check_eq("stale_len_ge14", 64'(pass_cycles >= 14), 64'd1);
    stale[0] = 1'b0;

    // Second edge 5 cycles after START is dropped.
    do_pass(0);
    evq.delete();
    start_req(lat);
    repeat (4) @(negedge clk);
    @(negedge clk); sample_clk = 1'b1;
    @(negedge clk); sample_clk = 1'b0;
    wait_idle();
    exp_ovr = 1;
    build_exp(N - 1, 1'b1);
    check_order("overrun_order");
    check_flags("overrun");
    do_clear();
    check_flags("cleared");

    // Request landing in DONE is dropped; no new pass starts.
    evq.delete();
    start_req(lat);
    wait_rst(2);
    repeat (2) @(negedge clk);
    sample_clk = 1'b1;
    @(negedge clk); sample_clk = 1'b0;
    repeat (10) @(negedge clk);
    exp_ovr = 1;
    check_eq("done_req_busy", 64'(busy), 64'd0);
    build_exp(N - 1, 1'b1);
    check_order("done_req_order");
    check_flags("done_req");
    do_clear();

    // Request landing in the first IDLE cycle after DONE is accepted.
    evq.delete();
    start_req(lat);
    wait_rst(2);
    repeat (3) @(negedge clk);
    sample_clk = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!lsb_clk && lat < 20);
    sample_clk = 1'b0;
    check_eq("b2b_latency", 64'(lat), 64'd3);
    set_delays(4);
    wait_idle();
    check_eq("b2b_pass_cycles", 64'(pass_cycles), 64'(exp_len()));
    check_flags("b2b");
    set_delays(3);

`ifdef SCHED_TIMEOUT_EN
    // Stage 1 hangs: abort after TIMEOUT WAIT cycles.
    prev_pc = pass_cycles;
    hang[1] = 1'b1;
    evq.delete();
    start_req(lat);
    wait_rst(1);
    lat = 0;
    while (busy && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check_eq("timeout_idle_after", 64'(lat), 64'(TO + 1));
    check_eq("timeout_err", 64'(timeout_err), 64'd1);
    check_eq("timeout_stage", 64'(timeout_stage), 64'd1);
    check_eq("timeout_pass_cycles", 64'(pass_cycles), 64'(prev_pc));
    build_exp(1, 1'b0);
    check_order("timeout_order");
    hang[1] = 1'b0;
    do_pass(0);
    check_eq("after_timeout_len", 64'(pass_cycles), 64'd16);
    do_clear();
    check_eq("timeout_err_clr", 64'(timeout_err), 64'd0);
    check_eq("timeout_stage_clr", 64'(timeout_stage), 64'd0);
`else
    // Stage 1 hangs: WAIT is unbounded.
    hang[1] = 1'b1;
    start_req(lat);
    wait_rst(1);
    repeat (20) @(negedge clk);
    check_eq("hung_busy", 64'(busy), 64'd1);
    check_eq("hung_timeout_err", 64'(timeout_err), 64'd0);
    check_eq("hung_timeout_stage", 64'(timeout_stage), 64'd0);
    pulse_reset();
    hang[1] = 1'b0;
`endif

    // Reset during WAIT of stage 1.
    do_pass(2);
    evq.delete();
    start_req(lat);
    wait_rst(1);
    pulse_reset();
    do_pass(0);
    check_eq("after_reset_len", 64'(pass_cycles), 64'd16);

    // Randomised passes.
    for (int it = 0; it < 12; it++) begin
      for (int i = 0; i < N; i++) delay_c[i] = int'($urandom_range(1, 5));
      stale[0] = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 2) == 0) do_clear();
      do_pass(int'($urandom_range(0, 3)));
      stale[0] = 1'b0;
    end

    // Saturation: preset the drop counter near full scale.
    set_delays(3);
    @(negedge clk);
    force dut.ovr_cnt_q = 16'hFFFC;
    repeat (2) @(negedge clk);
    release dut.ovr_cnt_q;
    exp_ovr = 16'hFFFC;
    do_pass(5);
    check_eq("saturated", 64'(overrun_count), 64'hFFFF);
    do_pass(2);

    // clear_err and a dropped request in the same cycle: count restarts at 1.
    evq.delete();
    start_req(lat);
    @(negedge clk); sample_clk = 1'b1;
    @(negedge clk); sample_clk = 1'b0;
    @(negedge clk); clear_err = 1'b1;
    @(negedge clk); clear_err = 1'b0;
    exp_ovr = 1;
    wait_idle();
    check_flags("clear_vs_overrun");
    check_eq("clear_vs_overrun_len", 64'(pass_cycles), 64'd16);

    check_eq("one_pulse_per_cycle", 64'(n_multi), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
